trace_dump_reader: RTL and testbench

// - Read-side drain for the MPSoC trace buffer: pops 32-bit trace words from the trace FIFO and streams them to a host byte link (UART TX / debug port) as framed packets.
// - Sits between the trace buffer read port (fifo_rd/fifo_dout) and a byte-wide valid/ready sink, in the same clock domain as the trace handler.
// - One frame per dump_start request; a frame ends when the FIFO is empty or MAX_WORDS words have been sent.

---
 rtl/trace_dump_pkg.sv | 25 ++
 rtl/trace_dump_chk.sv | 25 ++
 rtl/trace_dump_reader.sv | 148 ++++++++++++++
 tb/tb_trace_dump_reader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_dump_pkg.sv
// Shared types and constants for the trace dump reader: FSM states, SOF default,
// CRC-8 polynomial and the byte-index width helper.
package trace_dump_pkg;

   typedef enum logic [3:0] {
      StIdle   = 4'd0,
      StSof    = 4'd1,
      StCheck  = 4'd2,
      StRdReq  = 4'd3,
      StRdWait = 4'd4,
      StData   = 4'd5,
      StCount  = 4'd6,
      StChk    = 4'd7,
      StDone   = 4'd8
   } state_e;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;
   localparam logic [7:0] CRC8_POLY   = 8'h07;

   // Width of a counter indexing nb bytes; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

endpackage

// File: rtl/trace_dump_chk.sv
// Next-checksum step for one frame byte. Plain XOR by default; CRC-8 (poly 0x07,
// MSB-first, init 0) when TRACE_DUMP_CRC8_EN is defined.
module trace_dump_chk
   import trace_dump_pkg::*;
(
   input  logic [7:0] chk,
   input  logic [7:0] data,
   output logic [7:0] chk_next
);

`ifdef TRACE_DUMP_CRC8_EN
   logic [7:0] crc;

   always_comb begin
      crc = chk ^ data;
      for (int i = 0; i < 8; i++) begin
         crc = crc[7] ? ((crc << 1) ^ CRC8_POLY) : (crc << 1);
      end
      chk_next = crc;
   end
`else
   assign chk_next = chk ^ data;
`endif

endmodule

// File: rtl/trace_dump_reader.sv
// Drains the trace FIFO into framed byte packets: SOF, data bytes (MSB first), COUNT, CHK.
// CHK type is selected by TRACE_DUMP_CRC8_EN (CRC-8) versus the default XOR.
module trace_dump_reader
   import trace_dump_pkg::*;
#(
   parameter int unsigned Fpay      = 32,
   parameter int unsigned MAX_WORDS = 64,
   parameter logic [7:0]  SOF       = SOF_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            dump_start,
   input  logic            fifo_empty,
   output logic            fifo_rd,
   input  logic [Fpay-1:0] fifo_dout,
   output logic [7:0]      byte_out,
   output logic            byte_valid,
   input  logic            byte_ready,
   output logic            busy,
   output logic            frame_done,
   output logic [7:0]      words_sent
);

   localparam int unsigned NB       = Fpay / 8;
   localparam int unsigned IdxW     = idx_width(NB);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NB - 1);
   localparam logic [7:0]  MaxWords = 8'(MAX_WORDS);

   state_e          state_q, state_d;
   logic [Fpay-1:0] shift_q, shift_d, shifted;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [7:0]      words_q, words_d;
   logic [7:0]      chk_q, chk_d, chk_next;
   logic [7:0]      byte_q, byte_d;
   logic            valid_q, valid_d;
   logic            accept;

   assign accept  = valid_q && byte_ready;
   assign shifted = shift_q << 8;

   trace_dump_chk u_chk (
      .chk      (chk_q),
      .data     (byte_q),
      .chk_next (chk_next)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      words_d = words_q;
      chk_d   = chk_q;
      byte_d  = byte_q;
      valid_d = valid_q;
      unique case (state_q)
         StIdle: begin
            if (dump_start) begin
               state_d = StSof;
               words_d = 8'd0;
               chk_d   = 8'd0;
               byte_d  = SOF;
               valid_d = 1'b1;
            end
         end
         StSof: begin
            if (accept) begin
               valid_d = 1'b0;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (!fifo_empty && (words_q < MaxWords)) begin
               state_d = StRdReq;
            end else begin
               byte_d  = words_q;
               valid_d = 1'b1;
               state_d = StCount;
            end
         end
         StRdReq: state_d = StRdWait;
         StRdWait: begin
            // Popped word is valid now; present its top byte straight away.
            shift_d = fifo_dout;
            byte_d  = fifo_dout[Fpay-1 -: 8];
            valid_d = 1'b1;
            idx_d   = '0;
            state_d = StData;
         end
         StData: begin
            if (accept) begin
               chk_d = chk_next;
               if (idx_q == LastIdx) begin
                  words_d = words_q + 8'd1;
                  valid_d = 1'b0;
                  state_d = StCheck;
               end else begin
                  idx_d   = idx_q + IdxW'(1);
                  shift_d = shifted;
                  byte_d  = shifted[Fpay-1 -: 8];
               end
            end
         end
         StCount: begin
            if (accept) begin
               chk_d   = chk_next;
               byte_d  = chk_next;
               state_d = StChk;
            end
         end
         StChk: begin
            if (accept) begin
               valid_d = 1'b0;
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         shift_q <= '0;
         idx_q   <= '0;
         words_q <= 8'd0;
         chk_q   <= 8'd0;
         byte_q  <= 8'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         words_q <= words_d;
         chk_q   <= chk_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
      end
   end

   assign fifo_rd    = (state_q == StRdReq);
   assign busy       = (state_q != StIdle) && (state_q != StDone);
   assign frame_done = (state_q == StDone);
   assign byte_out   = byte_q;
   assign byte_valid = valid_q;
   assign words_sent = words_q;

endmodule

// File: tb/tb_trace_dump_reader.sv
// Scoreboard bench for trace_dump_reader: FIFO model, random ready stalls, frame reference
// model (XOR or CRC-8 when TRACE_DUMP_CRC8_EN is defined).
module tb_trace_dump_reader;

   localparam int unsigned Fpay = 32;
   localparam int unsigned MaxW = 64;
   localparam int unsigned NB   = Fpay / 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            dump_start;
   logic            fifo_empty;
   logic            fifo_rd;
   logic [Fpay-1:0] fifo_dout;
   logic [7:0]      byte_out;
   logic            byte_valid;
   logic            byte_ready;
   logic            busy;
   logic            frame_done;
   logic [7:0]      words_sent;

   always #5 clk = ~clk;

   trace_dump_reader #(
      .Fpay      (Fpay),
      .MAX_WORDS (MaxW),
      .SOF       (8'hA5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .dump_start (dump_start),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .fifo_dout  (fifo_dout),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .busy       (busy),
      .frame_done (frame_done),
      .words_sent (words_sent)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] fifo_q[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  exp_words_q[$];
   logic [7:0]  got_q[$];
   int          rd_count = 0;
   int          done_count = 0;
   bit          mon_en = 1'b0;
   bit          stall_en = 1'b0;
   bit          hold_pend = 1'b0;
   logic [7:0]  hold_byte;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Checksum reference, bit-serial formulation.
   function automatic logic [7:0] ref_update(input logic [7:0] c, input logic [7:0] b);
`ifdef TRACE_DUMP_CRC8_EN
      logic fb;
      for (int i = 7; i >= 0; i--) begin
         fb = c[7] ^ b[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
`else
      return c ^ b;
`endif
   endfunction

   // FIFO model: pop on fifo_rd, data visible the following cycle.
   always @(posedge clk) begin
      if (fifo_rd) begin
         rd_count++;
         if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
      end
   end

   always @(posedge clk) begin
      #1;
      byte_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   // Monitor: compares accepted bytes and frame-end status against the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         if (hold_pend) begin
            check("hold_valid", {31'd0, byte_valid}, 32'd1);
            check("hold_byte", {24'd0, byte_out}, {24'd0, hold_byte});
         end
         hold_pend = byte_valid && !byte_ready;
         hold_byte = byte_out;
         if (byte_valid && byte_ready) begin
            got_q.push_back(byte_out);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %h expected none", byte_out);
            end else begin
               check("byte", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
            end
         end
         if (fifo_rd) check("no_pop_when_empty", {31'd0, fifo_empty}, 32'd0);
         if (frame_done) begin
            done_count++;
            check("busy_at_done", {31'd0, busy}, 32'd0);
            check("frame_bytes_left", exp_q.size(), 32'd0);
            if (exp_words_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got frame_done expected none");
            end else begin
               check("words_sent", {24'd0, words_sent}, {24'd0, exp_words_q.pop_front()});
            end
         end
      end else begin
         hold_pend = 1'b0;
      end
      fifo_empty = (fifo_q.size() == 0);
   end

   task automatic pulse_start();
      @(negedge clk);
      dump_start = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
   endtask

   task automatic start_frame(output int n);
      logic [7:0] chk;
      logic [7:0] b;
      n   = (fifo_q.size() < MaxW) ? fifo_q.size() : MaxW;
      chk = 8'd0;
      exp_q.push_back(8'hA5);
      for (int w = 0; w < n; w++) begin
         for (int k = NB - 1; k >= 0; k--) begin
            b = fifo_q[w][8*k +: 8];
            exp_q.push_back(b);
            chk = ref_update(chk, b);
         end
      end
      exp_q.push_back(8'(n));
      chk = ref_update(chk, 8'(n));
      exp_q.push_back(chk);
      exp_words_q.push_back(8'(n));
      got_q.delete();
      pulse_start();
   endtask

   task automatic wait_done(input int start_cnt);
      int cyc = 0;
      while (done_count == start_cnt && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      if (done_count == start_cnt) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout: got no frame_done expected one within 5000 cycles");
      end
   endtask

   task automatic run_frame();
      int c;
      int n;
      c = done_count;
      start_frame(n);
      wait_done(c);
      repeat (3) @(negedge clk);
      check("words_hold", {24'd0, words_sent}, 32'(n));
   endtask

   task automatic push_random(input int cnt);
      for (int i = 0; i < cnt; i++) fifo_q.push_back($urandom());
   endtask

   logic [7:0] lit_one[7];
   int r0;
   int r1;
   int nf;
   int cs;

   initial begin
      reset      = 1'b1;
      dump_start = 1'b0;
      byte_ready = 1'b1;
      fifo_dout  = '0;
      fifo_empty = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_words_sent", {24'd0, words_sent}, 32'd0);
      check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
      check("rst_byte_out", {24'd0, byte_out}, 32'd0);
      reset  = 1'b0;
      mon_en = 1'b1;

      // Empty FIFO frame
      r0 = rd_count;
      run_frame();
      check("empty_no_rd", rd_count, r0);
      check("empty_len", got_q.size(), 32'd3);
      if (got_q.size() == 3) begin
         check("empty_b0", {24'd0, got_q[0]}, 32'hA5);
         check("empty_b1", {24'd0, got_q[1]}, 32'h00);
         check("empty_b2", {24'd0, got_q[2]}, 32'h00);
      end

      // One known word
      fifo_q.push_back(32'h11223344);
      repeat (2) @(negedge clk);
      r0 = rd_count;
      run_frame();
      check("one_word_rd_pulses", rd_count - r0, 32'd1);
`ifndef TRACE_DUMP_CRC8_EN
      lit_one = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h01, 8'h45};
      check("one_word_len", got_q.size(), 32'd7);
      if (got_q.size() == 7) begin
         for (int i = 0; i < 7; i++) check("one_word_byte", {24'd0, got_q[i]}, {24'd0, lit_one[i]});
      end
`endif

      fifo_q.push_back(32'h00000001);
      repeat (2) @(negedge clk);
      run_frame();

      // Frame limit: 70 queued, 64 sent, then the remaining 6
      push_random(70);
      repeat (2) @(negedge clk);
      run_frame();
      check("remaining_after_max", fifo_q.size(), 32'd6);
      run_frame();
      check("drained", fifo_q.size(), 32'd0);

      // Random sink stalls
      stall_en = 1'b1;
      push_random(12);
      repeat (2) @(negedge clk);
      run_frame();
      stall_en = 1'b0;

      // Extra dump_start mid-frame is dropped
      push_random(5);
      repeat (2) @(negedge clk);
      cs = done_count;
      start_frame(nf);
      repeat (15) @(negedge clk);
      check("busy_mid_frame", {31'd0, busy}, 32'd1);
      pulse_start();
      wait_done(cs);
      repeat (20) @(negedge clk);
      check("single_frame_only", done_count, cs + 1);
      check("idle_after_frame", {31'd0, busy}, 32'd0);

      // Reset mid-DATA aborts the frame
      push_random(8);
      repeat (2) @(negedge clk);
      mon_en = 1'b0;
      r0 = rd_count;
      pulse_start();
      begin
         int cyc = 0;
         while (rd_count < r0 + 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
         end
      end
      check("abort_reached_word2", rd_count - r0, 32'd2);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_byte_valid", {31'd0, byte_valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_fifo_rd", {31'd0, fifo_rd}, 32'd0);
      r1 = rd_count;
      repeat (10) @(negedge clk);
      check("abort_no_rd", rd_count, r1);
      check("abort_fifo_left", fifo_q.size(), 32'd6);
      exp_q.delete();
      exp_words_q.delete();
      mon_en = 1'b1;
      run_frame();
      check("fresh_sof", (got_q.size() > 0) ? {24'd0, got_q[0]} : 32'hFFFF_FFFF, 32'hA5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got no end of test expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
